mac3_tx: RTL and testbench

Transmit-side driver for the three-word multiply-accumulate stream port. Accepts operand triples (a, b, c) over a ready/valid request interface, buffers them in a small FIFO, and serializes each triple onto a single valid-qualified word bus as three back-to-back beats: a, then b, then c. This is the exact format the downstream accumulator requires to produce a*b+c. The block sits between a test/command source and the accumulator's `validi`/`data_in` inputs.

---
 rtl/mac3_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_mac3_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac3_tx.sv
// mac3_tx: transmit driver for the three-word multiply-accumulate stream.
// Buffers (a, b, c) operand triples in a FIFO. Each triple goes out on a
// valid-qualified word bus as three back-to-back beats a, b, c. After each
// triple the bus can be held idle for GAP cycles.
//
// Parameters: DW (word width), DEPTH (FIFO entries, power of 2, >= 2),
//             GAP (idle cycles after each triple, 0..15).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (req_ready = FIFO not full)
//   req_a, req_b, req_c      operand triple
//   tx_valid, tx_data        serialized stream toward the accumulator
//   level                    FIFO occupancy
//   busy                     a triple or its trailing gap is in progress
// Optional result checker, enabled by defining MAC3_TX_CHECK_EN:
//   res_valid, res_data      accumulator results coming back
//   chk_err                  sticky error (mismatch, underflow, overflow)
//   chk_cnt                  saturating count of results received
module mac3_tx #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DW-1:0]              req_a,
    input  logic [DW-1:0]              req_b,
    input  logic [DW-1:0]              req_c,
    output logic                       tx_valid,
    output logic [DW-1:0]              tx_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
`ifdef MAC3_TX_CHECK_EN
    ,
    input  logic                       res_valid,
    input  logic [DW-1:0]              res_data,
    output logic                       chk_err,
    output logic [15:0]                chk_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned TW = 3 * DW;
    localparam int unsigned GW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SA,
        S_SB,
        S_SC,
        S_GAPW
    } state_e;

    // ---------------- triple FIFO ----------------
    logic [TW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push, pop;
    logic [TW-1:0] head;

    assign req_ready = (level_q != LW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = mem_q[rd_ptr_q];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_a, req_b, req_c};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (!push && pop) level_q <= level_q - LW'(1);
        end
    end

    // ---------------- serializer FSM ----------------
    state_e          state_q, state_d;
    logic            tx_valid_q, tx_valid_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [2*DW-1:0] cur_q, cur_d;      // {b, c} of the triple in flight
    logic            busy_q;
    logic            try_start;

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        gap_d      = gap_q;
        cur_d      = cur_q;
        pop        = 1'b0;
        try_start  = 1'b0;

        unique case (state_q)
            S_IDLE: try_start = 1'b1;
            S_SA: begin
                tx_data_d = cur_q[2*DW-1 -: DW];
                state_d   = S_SB;
            end
            S_SB: begin
                tx_data_d = cur_q[DW-1:0];
                state_d   = S_SC;
            end
            S_SC: begin
                if (GAP == 0) begin
                    try_start = 1'b1;
                end else begin
                    tx_valid_d = 1'b0;
                    gap_d      = GW'(GAP - 1);
                    state_d    = S_GAPW;
                end
            end
            S_GAPW: begin
                if (gap_q == '0) try_start = 1'b1;
                else             gap_d = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Shared IDLE behaviour: start the next triple if one is queued.
        if (try_start) begin
            if (level_q != '0) begin
                pop        = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = head[TW-1 -: DW];
                cur_d      = head[2*DW-1:0];
                state_d    = S_SA;
            end else begin
                tx_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            gap_q      <= '0;
            cur_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            gap_q      <= gap_d;
            cur_q      <= cur_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign level    = level_q;
    assign busy     = busy_q;

`ifdef MAC3_TX_CHECK_EN
    // ---------------- result checker ----------------
    logic [DW-1:0]   cur_a_q;
    logic [DW-1:0]   exp_mem_q [2];
    logic            eq_wr_q, eq_rd_q;
    logic [1:0]      eq_cnt_q;
    logic            c_beat, eq_push, eq_pop;
    logic            mismatch, underflow, overflow;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   exp_val;
    logic            chk_err_q;
    logic [15:0]     chk_cnt_q;

    // The edge leaving SB is the one that puts c on the bus.
    assign c_beat    = (state_q == S_SB);
    assign prod      = (2*DW)'(cur_a_q) * (2*DW)'(cur_q[2*DW-1 -: DW]);
    assign exp_val   = DW'(prod + (2*DW)'(cur_q[DW-1:0]));
    assign eq_pop    = res_valid && (eq_cnt_q != 2'd0);
    assign underflow = res_valid && (eq_cnt_q == 2'd0);
    assign mismatch  = eq_pop && (exp_mem_q[eq_rd_q] != res_data);
    assign overflow  = c_beat && (eq_cnt_q == 2'd2) && !eq_pop;
    assign eq_push   = c_beat && !overflow;

    always_ff @(posedge clk) begin
        if (eq_push) begin
            exp_mem_q[eq_wr_q] <= exp_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_a_q   <= '0;
            eq_wr_q   <= 1'b0;
            eq_rd_q   <= 1'b0;
            eq_cnt_q  <= '0;
            chk_err_q <= 1'b0;
            chk_cnt_q <= '0;
        end else begin
            if (pop) cur_a_q <= head[TW-1 -: DW];
            if (eq_push) eq_wr_q <= ~eq_wr_q;
            if (eq_pop)  eq_rd_q <= ~eq_rd_q;
            if (eq_push && !eq_pop)      eq_cnt_q <= eq_cnt_q + 2'd1;
            else if (!eq_push && eq_pop) eq_cnt_q <= eq_cnt_q - 2'd1;
            if (mismatch || underflow || overflow) chk_err_q <= 1'b1;
            if (res_valid && (chk_cnt_q != 16'hFFFF)) chk_cnt_q <= chk_cnt_q + 16'd1;
        end
    end

    assign chk_err = chk_err_q;
    assign chk_cnt = chk_cnt_q;
`endif

endmodule

// File: tb/tb_mac3_tx.sv
// Bench for mac3_tx: two instances (GAP=0 and GAP=2) share the request
// stimulus; a queue-style reference model predicts each one's output stream.
module tb_mac3_tx;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int          GAP_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic [DW-1:0] req_a = '0, req_b = '0, req_c = '0;

    logic          tv [2];
    logic [DW-1:0] td [2];
    logic [LW-1:0] lv [2];
    logic          bz [2];
    logic          rr [2];

    int checks = 0;
    int errors = 0;

`ifdef MAC3_TX_CHECK_EN
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          chk_err;
    logic [15:0]   chk_cnt;
    logic          chk_err_b;
    logic [15:0]   chk_cnt_b;
    logic          res_valid_b = 1'b0;
    logic [DW-1:0] res_data_b = '0;
`endif

    always #5 clk = ~clk;

    mac3_tx #(.DW(DW), .DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rr[0]),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .tx_valid(tv[0]), .tx_data(td[0]), .level(lv[0]), .busy(bz[0])
`ifdef MAC3_TX_CHECK_EN
        , .res_valid(res_valid), .res_data(res_data),
        .chk_err(chk_err), .chk_cnt(chk_cnt)
`endif
    );

    mac3_tx #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP_B)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rr[1]),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .tx_valid(tv[1]), .tx_data(td[1]), .level(lv[1]), .busy(bz[1])
`ifdef MAC3_TX_CHECK_EN
        , .res_valid(res_valid_b), .res_data(res_data_b),
        .chk_err(chk_err_b), .chk_cnt(chk_cnt_b)
`endif
    );

    // Reference model: a plain list of queued triples per instance, plus the
    // position inside the triple/gap currently being played out.
    logic [3*DW-1:0] mf [2][DEPTH];
    int              mc [2];
    logic [2*DW-1:0] mcur [2];
    int              pos [2];
    bit              act [2];
    logic            ev [2];
    logic [DW-1:0]   ed [2];
    logic            eb [2];

    function automatic int gapof(int d);
        return (d == 0) ? 0 : GAP_B;
    endfunction

    initial begin : model
        bit psh;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    mc[d] = 0; act[d] = 0; pos[d] = 0;
                    ev[d] = 1'b0; ed[d] = '0; eb[d] = 1'b0;
                end else begin
                    psh = req_valid && (mc[d] < int'(DEPTH));
                    if (act[d] && pos[d] < 2 + gapof(d)) begin
                        pos[d]++;
                        ev[d] = (pos[d] <= 2);
                        if (pos[d] == 1)      ed[d] = mcur[d][2*DW-1 -: DW];
                        else if (pos[d] == 2) ed[d] = mcur[d][DW-1:0];
                        eb[d] = 1'b1;
                    end else if (mc[d] > 0) begin
                        ed[d]   = mf[d][0][3*DW-1 -: DW];
                        mcur[d] = mf[d][0][2*DW-1:0];
                        for (int i = 0; i < int'(DEPTH) - 1; i++) mf[d][i] = mf[d][i+1];
                        mc[d]--;
                        act[d] = 1; pos[d] = 0; ev[d] = 1'b1; eb[d] = 1'b1;
                    end else begin
                        act[d] = 0; ev[d] = 1'b0; eb[d] = 1'b0;
                    end
                    if (psh) begin
                        mf[d][mc[d]] = {req_a, req_b, req_c};
                        mc[d]++;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bz[0] == 1'b0 && bz[1] == 1'b0 && lv[0] == '0 && lv[1] == '0) && n < 100);
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b/%b level=%0d/%0d after %0d cycles, want all zero", bz[0], bz[1], lv[0], lv[1], n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({tv[d], td[d], lv[d], bz[d], rr[d]} !== {1'b0, {DW{1'b0}}, {LW{1'b0}}, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_dut%0d: got v=%b d=%h lvl=%0d busy=%b rdy=%b, want 0/0/0/0/1", d, tv[d], td[d], lv[d], bz[d], rr[d]);
            end
        end
`ifdef MAC3_TX_CHECK_EN
        checks++;
        if ({chk_err, chk_cnt} !== 17'd0) begin
            errors++;
            $display("FAIL reset_chk: got err=%b cnt=%0d, want 0/0", chk_err, chk_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] e [3];
        e[0] = 3; e[1] = 5; e[2] = 7;
        @(negedge clk);
        req_valid = 1'b1; req_a = 3; req_b = 5; req_c = 7;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({tv[0], lv[0]} !== {1'b0, LW'(1)}) begin
            errors++;
            $display("FAIL single_push: got v=%b lvl=%0d, want v=0 lvl=1", tv[0], lv[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tv[0], td[0], bz[0]} !== {1'b1, e[i], 1'b1}) begin
                errors++;
                $display("FAIL single_beat%0d: got v=%b d=%0d busy=%b, want v=1 d=%0d busy=1", i, tv[0], td[0], bz[0], e[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({tv[0], td[0], bz[0], lv[0]} !== {1'b0, DW'(7), 1'b0, LW'(0)}) begin
            errors++;
            $display("FAIL single_end: got v=%b d=%0d busy=%b lvl=%0d, want v=0 d=7 busy=0 lvl=0", tv[0], td[0], bz[0], lv[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3*DW-1:0] tr [7];
        logic [DW-1:0]   got [$];
        logic [DW-1:0]   w;
        int n, run, maxrun, bad;
        bit stall, acc;
        for (int i = 0; i < 7; i++) tr[i] = {$urandom(), $urandom(), $urandom()};
        n = 0; run = 0; maxrun = 0; stall = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (tv[0]) begin
                got.push_back(td[0]);
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({tv[d], td[d], lv[d], bz[d], rr[d]} !== {ev[d], ed[d], LW'(mc[d]), eb[d], mc[d] < int'(DEPTH)}) begin
                    errors++;
                    $display("FAIL b2b_model_dut%0d cyc%0d: got v=%b d=%h lvl=%0d busy=%b, want v=%b d=%h lvl=%0d busy=%b", d, cyc, tv[d], td[d], lv[d], bz[d], ev[d], ed[d], mc[d], eb[d]);
                end
            end
            if (n < 7) begin
                req_valid = 1'b1;
                {req_a, req_b, req_c} = tr[n];
                if (!rr[0]) stall = 1;
                acc = rr[0];
            end else begin
                req_valid = 1'b0;
                acc = 0;
            end
            @(posedge clk);
            if (acc) n++;
        end
        req_valid = 1'b0;
        checks++;
        if (!stall || maxrun != 21) begin
            errors++;
            $display("FAIL b2b_stream: got stall_seen=%0d longest_run=%0d, want stall_seen=1 longest_run=21", stall, maxrun);
        end
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            w = tr[i/3][3*DW-1 - (i%3)*DW -: DW];
            if (i >= got.size() || got[i] !== w) bad++;
        end
        checks++;
        if (bad != 0 || got.size() != 21) begin
            errors++;
            $display("FAIL b2b_order: got %0d beats with %0d out of order, want 21 beats in order", got.size(), bad);
        end
    endtask

    task automatic test_gap();
        logic [3*DW-1:0] tr [2];
        logic [DW:0]     exp_tr [$];
        logic [DW-1:0]   last;
        for (int i = 0; i < 2; i++) tr[i] = {$urandom(), $urandom(), $urandom()};
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 3; k++) exp_tr.push_back({1'b1, tr[t][3*DW-1 - k*DW -: DW]});
            last = tr[t][DW-1:0];
            for (int g = 0; g < GAP_B; g++) exp_tr.push_back({1'b0, last});
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            req_valid = 1'b1;
            {req_a, req_b, req_c} = tr[t];
        end
        for (int j = 0; j < exp_tr.size(); j++) begin
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if ({tv[1], td[1]} !== exp_tr[j]) begin
                errors++;
                $display("FAIL gap_beat%0d: got v=%b d=%h, want v=%b d=%h", j, tv[1], td[1], exp_tr[j][DW], exp_tr[j][DW-1:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({tv[d], td[d], lv[d], bz[d], rr[d]} !== {ev[d], ed[d], LW'(mc[d]), eb[d], mc[d] < int'(DEPTH)}) begin
                    errors++;
                    $display("FAIL rand_dut%0d cyc%0d: got v=%b d=%h lvl=%0d busy=%b rdy=%b, want v=%b d=%h lvl=%0d busy=%b rdy=%b", d, cyc, tv[d], td[d], lv[d], bz[d], rr[d], ev[d], ed[d], mc[d], eb[d], mc[d] < int'(DEPTH));
                end
            end
            req_valid = ($urandom_range(99) < 55);
            req_a = $urandom(); req_b = $urandom(); req_c = $urandom();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3*DW-1:0] tr [3];
        for (int i = 0; i < 3; i++) tr[i] = {$urandom(), $urandom(), $urandom()};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            req_valid = 1'b1;
            {req_a, req_b, req_c} = tr[t];
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({tv[0], td[0], lv[0]} !== {1'b1, tr[0][2*DW-1 -: DW], LW'(2)}) begin
            errors++;
            $display("FAIL rstmid_sb: got v=%b d=%h lvl=%0d, want v=1 d=%h lvl=2", tv[0], td[0], lv[0], tr[0][2*DW-1 -: DW]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tv[0], lv[0], bz[0], rr[0]} !== {1'b0, LW'(0), 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b lvl=%0d busy=%b rdy=%b, want 0/0/0/1", tv[0], lv[0], bz[0], rr[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({tv[0], lv[0], bz[0]} !== 3'b0 || {tv[1], lv[1], bz[1]} !== 3'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: got v=%b/%b lvl=%0d/%0d busy=%b/%b, want all zero", i, tv[0], tv[1], lv[0], lv[1], bz[0], bz[1]);
            end
        end
    endtask

`ifdef MAC3_TX_CHECK_EN
    task automatic test_checker();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            req_valid = 1'b1; req_a = 32'hFFFF_FFFF; req_b = 2; req_c = 1;
            @(negedge clk);
            req_valid = 1'b0;
            repeat (3) @(negedge clk);
            res_valid = 1'b1;
            res_data  = (r == 0) ? 32'hFFFF_FFFF : 32'h0;
            @(negedge clk);
            res_valid = 1'b0;
            checks++;
            if ({chk_err, chk_cnt} !== {(r == 1), 16'(r + 1)}) begin
                errors++;
                $display("FAIL chk_result%0d: got err=%b cnt=%0d, want err=%0d cnt=%0d", r, chk_err, chk_cnt, r, r + 1);
            end
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        res_valid = 1'b1; res_data = '0;
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if ({chk_err, chk_cnt} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL chk_underflow: got err=%b cnt=%0d, want err=1 cnt=1", chk_err, chk_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        wait_idle();
        test_back_to_back();
        wait_idle();
        test_gap();
        wait_idle();
        test_random();
        wait_idle();
        test_reset_mid();
`ifdef MAC3_TX_CHECK_EN
        test_checker();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
